// File: rtl/memory_access.sv
// rtl/memory_access.sv - load/store stage: bus handshake, alignment check, load formatting
// Results are registered toward writeback; upstream stall is combinational.
module memory_access #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int OPCODE_WIDTH = 11,
  parameter int LOAD_WORD    = 3,
  parameter int STORE_WORD   = 4
) (
  input  logic                    e_clk,
  input  logic                    e_rst,
  input  logic                    m_i_ce,
  input  logic [OPCODE_WIDTH-1:0] m_i_opcode,
  input  logic [2:0]              m_i_funct3,
  input  logic [DWIDTH-1:0]       m_i_addr,
  input  logic [DWIDTH-1:0]       m_i_rs2,
  input  logic [AWIDTH-1:0]       m_i_addr_rd,
  input  logic [DWIDTH-1:0]       m_i_data_rd,
  input  logic                    m_i_we,
  input  logic [PC_WIDTH-1:0]     m_i_pc,
  input  logic                    m_i_stall,
  input  logic                    m_i_flush,
  output logic                    m_o_stb,
  output logic                    m_o_wr,
  output logic [DWIDTH-1:0]       m_o_bus_addr,
  output logic [DWIDTH-1:0]       m_o_wdata,
  output logic [3:0]              m_o_sel,
  input  logic                    m_i_ack,
  input  logic [DWIDTH-1:0]       m_i_rdata,
  output logic                    m_o_ce,
  output logic [AWIDTH-1:0]       m_o_addr_rd,
  output logic [DWIDTH-1:0]       m_o_data_rd,
  output logic                    m_o_we,
  output logic [PC_WIDTH-1:0]     m_o_pc,
  output logic                    m_o_misaligned,
  output logic                    m_o_stall
);

  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;
  state_t state;

  // Fields of the in-flight access, kept until its result is presented
  logic [2:0]          p_funct3;
  logic [1:0]          p_off;
  logic                p_load;
  logic                p_we;
  logic                p_drop;
  logic [AWIDTH-1:0]   p_addr_rd;
  logic [DWIDTH-1:0]   p_data_rd;
  logic [PC_WIDTH-1:0] p_pc;
  logic [DWIDTH-1:0]   p_buf;

  logic              is_load, is_store, is_mem, misaligned_c, complete_c, drop_c;
  logic [3:0]        sel_c;
  logic [DWIDTH-1:0] wdata_c, lane, ldata_c, res_data;

  always_comb begin
    is_load  = m_i_opcode[LOAD_WORD];
    is_store = m_i_opcode[STORE_WORD] & ~is_load;
    is_mem   = is_load | is_store;
    case (m_i_funct3[1:0])
      2'b00: begin
        misaligned_c = 1'b0;
        sel_c        = 4'b0001 << m_i_addr[1:0];
        wdata_c      = {4{m_i_rs2[7:0]}};
      end
      2'b01: begin
        misaligned_c = m_i_addr[0];
        sel_c        = 4'b0011 << m_i_addr[1:0];
        wdata_c      = {2{m_i_rs2[15:0]}};
      end
      default: begin
        misaligned_c = |m_i_addr[1:0];
        sel_c        = 4'b1111;
        wdata_c      = m_i_rs2;
      end
    endcase

    lane = m_i_rdata >> {p_off, 3'b000};
    case (p_funct3)
      3'b000:  ldata_c = {{(DWIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  ldata_c = {{(DWIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  ldata_c = {{(DWIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  ldata_c = {{(DWIDTH-16){1'b0}}, lane[15:0]};
      default: ldata_c = m_i_rdata;
    endcase

    complete_c = !m_i_stall && ((state == BUS && m_i_ack) || state == HOLD);
    drop_c     = p_drop | m_i_flush;
    res_data   = (state == HOLD) ? p_buf : ldata_c;
    m_o_stall  = (state != IDLE) || m_i_stall;
  end

  always_ff @(posedge e_clk or negedge e_rst) begin
    if (!e_rst) begin
      state          <= IDLE;
      m_o_stb        <= 1'b0;
      m_o_wr         <= 1'b0;
      m_o_bus_addr   <= '0;
      m_o_wdata      <= '0;
      m_o_sel        <= 4'b0000;
      m_o_ce         <= 1'b0;
      m_o_addr_rd    <= '0;
      m_o_data_rd    <= '0;
      m_o_we         <= 1'b0;
      m_o_pc         <= '0;
      m_o_misaligned <= 1'b0;
      p_funct3       <= 3'b000;
      p_off          <= 2'b00;
      p_load         <= 1'b0;
      p_we           <= 1'b0;
      p_drop         <= 1'b0;
      p_addr_rd      <= '0;
      p_data_rd      <= '0;
      p_pc           <= '0;
      p_buf          <= '0;
    end else begin
      case (state)
        IDLE: if (!m_i_stall) begin
          m_o_ce         <= 1'b0;
          m_o_we         <= 1'b0;
          m_o_misaligned <= 1'b0;
          if (m_i_ce && !m_i_flush) begin
            if (!is_mem || misaligned_c) begin
              m_o_ce         <= 1'b1;
              m_o_we         <= is_mem ? 1'b0 : m_i_we;
              m_o_misaligned <= is_mem;
              m_o_addr_rd    <= m_i_addr_rd;
              m_o_data_rd    <= m_i_data_rd;
              m_o_pc         <= m_i_pc;
            end else begin
              state        <= BUS;
              m_o_stb      <= 1'b1;
              m_o_wr       <= is_store;
              m_o_bus_addr <= {m_i_addr[DWIDTH-1:2], 2'b00};
              m_o_sel      <= sel_c;
              m_o_wdata    <= wdata_c;
              p_funct3     <= m_i_funct3;
              p_off        <= m_i_addr[1:0];
              p_load       <= is_load;
              p_we         <= m_i_we;
              p_drop       <= 1'b0;
              p_addr_rd    <= m_i_addr_rd;
              p_data_rd    <= m_i_data_rd;
              p_pc         <= m_i_pc;
            end
          end
        end
        BUS: begin
          if (m_i_flush) p_drop <= 1'b1;
          if (m_i_ack) begin
            m_o_stb <= 1'b0;
            m_o_wr  <= 1'b0;
            if (m_i_stall) begin
              p_buf <= ldata_c;
              state <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (m_i_flush) p_drop <= 1'b1;
          if (!m_i_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A flushed access still finishes on the bus but leaves no trace in writeback
      if (complete_c) begin
        m_o_ce         <= ~drop_c;
        m_o_we         <= p_load & p_we & ~drop_c;
        m_o_misaligned <= 1'b0;
        m_o_data_rd    <= p_load ? res_data : p_data_rd;
        m_o_addr_rd    <= p_addr_rd;
        m_o_pc         <= p_pc;
      end
    end
  end

endmodule
